// File: rtl/pipeline_insertion_sort.sv
// Batch sorter: entries are inserted one per cycle into a sorted register array, then drained in order.
// Define PIPELINE_SORT_DESCENDING_EN for descending order (stable in both directions).
module pipeline_insertion_sort #(
   parameter int KEY_W = 8,
   parameter int TAG_W = 6,
   parameter int DEPTH = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [KEY_W-1:0]           in_key,
   input  logic [TAG_W-1:0]           in_tag,
   input  logic                       start,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [KEY_W-1:0]           out_key,
   output logic [TAG_W-1:0]           out_tag,
   output logic                       out_last,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       done_out
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   localparam logic [1:0] S_LOAD  = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q;
   logic [CNT_W-1:0] count_q;
   logic [IDX_W-1:0] rd_idx_q;
   logic [KEY_W-1:0] key_q [DEPTH];
   logic [TAG_W-1:0] tag_q [DEPTH];
   logic [DEPTH-1:0] moves;
   logic             accept;
   logic             at_last;

   assign in_ready  = (state_q == S_LOAD) && (count_q < CNT_W'(DEPTH));
   assign accept    = rst_n && !clear && in_valid && in_ready;
   assign out_valid = (state_q == S_DRAIN);
   assign at_last   = (CNT_W'(rd_idx_q) == count_q - CNT_W'(1));
   assign out_last  = out_valid && at_last;
   assign out_key   = key_q[rd_idx_q];
   assign out_tag   = tag_q[rd_idx_q];
   assign count     = count_q;
   assign done_out  = (state_q == S_DONE) && !clear;

   // moves[i]: occupied slot i must shift up to make room for the new entry.
   // Equal keys never move, which is what keeps the sort stable.
   always_comb begin
      // NOTE: every bit gets a default before the loop so no latch is inferred.
      moves = '0;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef PIPELINE_SORT_DESCENDING_EN
         moves[i] = (CNT_W'(i) < count_q) && (key_q[i] < in_key);
`else
         moves[i] = (CNT_W'(i) < count_q) && (key_q[i] > in_key);
`endif
      end
   end

   // NOTE: the entry array has no reset; count_q alone defines which slots are valid.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (moves[0] || count_q == '0) begin
            key_q[0] <= in_key;
            tag_q[0] <= in_tag;
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (moves[i-1]) begin
               key_q[i] <= key_q[i-1];
               tag_q[i] <= tag_q[i-1];
            end else if (moves[i] || CNT_W'(i) == count_q) begin
               key_q[i] <= in_key;
               tag_q[i] <= in_tag;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state_q  <= S_LOAD;
         count_q  <= '0;
         rd_idx_q <= '0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (accept) count_q <= count_q + CNT_W'(1);
               if (start) begin
                  state_q  <= (accept || count_q != '0) ? S_DRAIN : S_DONE;
                  rd_idx_q <= '0;
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  if (at_last) begin
                     state_q <= S_DONE;
                     count_q <= '0;
                  end else begin
                     rd_idx_q <= rd_idx_q + IDX_W'(1);
                  end
               end
            end
            S_DONE: begin
               state_q <= S_LOAD;
               count_q <= '0;
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_insertion_sort.sv
// Self-checking bench for pipeline_insertion_sort: directed tables, corner sequences, random batches.
module tb_pipeline_insertion_sort;

   localparam int KEY_W = 8;
   localparam int TAG_W = 6;
   localparam int DEPTH = 10;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 0;
   logic             rst_n, clear, in_valid, in_ready, start;
   logic             out_valid, out_ready, out_last, done_out;
   logic [KEY_W-1:0] in_key, out_key;
   logic [TAG_W-1:0] in_tag, out_tag;
   logic [CNT_W-1:0] count;

   pipeline_insertion_sort #(.KEY_W(KEY_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_tag(in_tag),
      .start(start),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_key(out_key), .out_tag(out_tag), .out_last(out_last),
      .count(count), .done_out(done_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [TAG_W-1:0] tag;
   } entry_t;

   typedef struct {
      string  name;
      int     n;
      entry_t in_e  [4];
      entry_t exp_e [4];
   } vec_t;

   int     checks = 0;
   int     errors = 0;
   entry_t arr_q[$];
   entry_t exp_q[$];
   int     rdy_pat[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit earlier(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
`ifdef PIPELINE_SORT_DESCENDING_EN
      return a > b;
`else
      return a < b;
`endif
   endfunction

   // Reference: stable selection sort over the arrival-ordered batch.
   function automatic void ref_sort();
      entry_t pool[$];
      pool = arr_q;
      exp_q.delete();
      while (pool.size() > 0) begin
         int best = 0;
         for (int i = 1; i < pool.size(); i++)
            if (earlier(pool[i].key, pool[best].key)) best = i;
         exp_q.push_back(pool[best]);
         pool.delete(best);
      end
   endfunction

   task automatic load_one(input logic [KEY_W-1:0] k, input logic [TAG_W-1:0] t, input bit with_start);
      bit room;
      room     = (arr_q.size() < DEPTH);
      in_valid = 1;
      in_key   = k;
      in_tag   = t;
      start    = with_start;
      check("in_ready", in_ready, room);
      if (room) arr_q.push_back({k, t});
      step();
      in_valid = 0;
      start    = 0;
      if (!with_start) check("count", count, arr_q.size());
   endtask

   // mode 0: out_ready=1, 1: rdy_pat, 2: random out_ready and stray start pulses
   task automatic drain_check(input string name, input bit do_start, input int mode);
      int n, idx, cyc;
      n = exp_q.size();
      if (do_start) begin
         start = 1;
         step();
         start = 0;
      end
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 300) begin
         if (mode == 0) out_ready = 1;
         else if (mode == 1) out_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() != 0 : 1'b1;
         else begin
            out_ready = $urandom_range(0, 1);
            start     = $urandom_range(0, 1);
         end
         check({name, " out_valid"}, out_valid, 1);
         check({name, " out_key"}, out_key, exp_q[idx].key);
         check({name, " out_tag"}, out_tag, exp_q[idx].tag);
         check({name, " out_last"}, out_last, idx == n - 1);
         check({name, " done_early"}, done_out, 0);
         if (out_ready) idx++;
         step();
         cyc++;
      end
      start = 0;
      check({name, " drain_timeout"}, cyc < 300, 1);
      check({name, " valid_drop"}, out_valid, 0);
      check({name, " done_pulse"}, done_out, 1);
      step();
      check({name, " done_clr"}, done_out, 0);
      check({name, " count_zero"}, count, 0);
      check({name, " ready_again"}, in_ready, 1);
      out_ready = 0;
      arr_q.delete();
   endtask

   task automatic abort_case(input bit use_reset);
      string nm;
      int    pulses;
      nm = use_reset ? "reset_abort" : "clear_abort";
      for (int i = 0; i < 5; i++) load_one(KEY_W'($urandom_range(0, 255)), TAG_W'(i), 0);
      ref_sort();
      start = 1;
      step();
      start     = 0;
      out_ready = 1;
      for (int i = 0; i < 2; i++) begin
         check({nm, " pre_key"}, out_key, exp_q[i].key);
         step();
      end
      out_ready = 0;
      if (use_reset) rst_n = 0;
      else clear = 1;
      step();
      rst_n = 1;
      clear = 0;
      check({nm, " out_valid"}, out_valid, 0);
      check({nm, " count"}, count, 0);
      check({nm, " in_ready"}, in_ready, 1);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         pulses += int'(done_out);
         step();
      end
      check({nm, " no_done"}, pulses, 0);
      arr_q.delete();
      load_one(8'd7, 6'd1, 0);
      load_one(8'd2, 6'd2, 0);
      load_one(8'd7, 6'd3, 0);
      ref_sort();
      drain_check({nm, " reload"}, 1, 0);
   endtask

   vec_t vecs[3];

   initial begin
      int pulses, ovs, n;

      vecs[0].name = "req033";
      vecs[0].n    = 4;
      vecs[0].in_e = '{{8'd5, 6'd0}, {8'd3, 6'd1}, {8'd9, 6'd2}, {8'd1, 6'd3}};
      vecs[1].name = "req034";
      vecs[1].n    = 4;
      vecs[1].in_e = '{{8'd4, 6'd0}, {8'd4, 6'd1}, {8'd2, 6'd2}, {8'd4, 6'd3}};
      vecs[2].name = "unsigned";
      vecs[2].n    = 4;
      vecs[2].in_e = '{{8'd0, 6'd0}, {8'd255, 6'd1}, {8'd255, 6'd2}, {8'd0, 6'd3}};
`ifdef PIPELINE_SORT_DESCENDING_EN
      vecs[0].exp_e = '{{8'd9, 6'd2}, {8'd5, 6'd0}, {8'd3, 6'd1}, {8'd1, 6'd3}};
      vecs[1].exp_e = '{{8'd4, 6'd0}, {8'd4, 6'd1}, {8'd4, 6'd3}, {8'd2, 6'd2}};
      vecs[2].exp_e = '{{8'd255, 6'd1}, {8'd255, 6'd2}, {8'd0, 6'd0}, {8'd0, 6'd3}};
`else
      vecs[0].exp_e = '{{8'd1, 6'd3}, {8'd3, 6'd1}, {8'd5, 6'd0}, {8'd9, 6'd2}};
      vecs[1].exp_e = '{{8'd2, 6'd2}, {8'd4, 6'd0}, {8'd4, 6'd1}, {8'd4, 6'd3}};
      vecs[2].exp_e = '{{8'd0, 6'd0}, {8'd0, 6'd3}, {8'd255, 6'd1}, {8'd255, 6'd2}};
`endif

      rst_n = 0; clear = 0; in_valid = 0; in_key = '0; in_tag = '0;
      start = 0; out_ready = 0;
      step();
      step();
      check("rst out_valid", out_valid, 0);
      check("rst out_last", out_last, 0);
      check("rst done_out", done_out, 0);
      check("rst count", count, 0);
      rst_n = 1;
      step();
      check("rst in_ready", in_ready, 1);

      // Directed tables
      foreach (vecs[v]) begin
         for (int i = 0; i < vecs[v].n; i++) load_one(vecs[v].in_e[i].key, vecs[v].in_e[i].tag, 0);
         exp_q.delete();
         for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].exp_e[i]);
         drain_check(vecs[v].name, 1, 0);
      end

      // Overfill: in_valid held across DEPTH+2 offers
      for (int i = 0; i < DEPTH + 2; i++) load_one(KEY_W'($urandom_range(0, 15)), TAG_W'(i), 0);
      check("full in_ready", in_ready, 0);
      check("full count", count, DEPTH);
      ref_sort();
      drain_check("full", 1, 0);

      // Empty batch start
      start = 1;
      step();
      start  = 0;
      pulses = 0;
      ovs    = 0;
      for (int i = 0; i < 4; i++) begin
         pulses += int'(done_out);
         ovs    += int'(out_valid);
         step();
      end
      check("empty done_pulses", pulses, 1);
      check("empty out_valid", ovs, 0);
      check("empty in_ready", in_ready, 1);

      // Stall pattern on a 3-entry batch
      load_one(8'd30, 6'd0, 0);
      load_one(8'd10, 6'd1, 0);
      load_one(8'd20, 6'd2, 0);
      ref_sort();
      rdy_pat = '{1, 0, 0, 1, 1};
      drain_check("stall", 1, 1);

      // Start coincident with the final insert
      load_one(8'd50, 6'd5, 0);
      load_one(8'd40, 6'd6, 0);
      load_one(8'd45, 6'd7, 1);
      ref_sort();
      drain_check("start_ins", 0, 0);

      abort_case(0);
      abort_case(1);

      // Random batches, narrow key range to force ties
      for (int b = 0; b < 25; b++) begin
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++)
            load_one(KEY_W'($urandom_range(0, (b % 2) ? 255 : 5)), TAG_W'($urandom_range(0, 63)), 0);
         ref_sort();
         drain_check("random", 1, 2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
